// File: rtl/rv32i_types.sv
// Shared types for the out-of-order memory pipeline.
//   ROB_WIDTH   : width of a reorder-buffer index
//   PR_WIDTH    : width of a physical register tag
//   cdb_t       : one common-data-bus broadcast (valid, arch dest, phys tag)
//   lsq_entry_t : one load/store queue entry as held in the queue and
//                 as presented to the memory functional unit
package rv32i_types;

  localparam int ROB_WIDTH = 4;
  localparam int PR_WIDTH  = 6;

  typedef struct packed {
    logic                cdb_valid;
    logic [4:0]          arch_reg;
    logic [PR_WIDTH-1:0] phys_reg;
  } cdb_t;

  typedef struct packed {
    logic                 valid;
    logic                 is_store;
    logic [2:0]           funct3;
    logic [31:0]          offset;
    logic [ROB_WIDTH-1:0] rob;
    logic [PR_WIDTH-1:0]  prs1;
    logic                 addr_rdy;
    logic [PR_WIDTH-1:0]  prs2;
    logic                 data_rdy;
    logic [PR_WIDTH-1:0]  pdest;
    logic [4:0]           arch_dest;
  } lsq_entry_t;

endpackage

// File: rtl/lsq_wakeup.sv
// Operand wakeup comparator: flags when any CDB port broadcasts the given
// physical tag this cycle.
//   tag : physical register the operand is waiting on
//   cdb : all CDB ports snooped this cycle
//   hit : 1 when a valid broadcast matches tag
// Broadcasts to architectural x0 never wake anything: x0 writes are
// discarded, so their physical tag carries no real value.
module lsq_wakeup
  import rv32i_types::*;
#(
  parameter int NUM_CDB = 2
) (
  input  logic [PR_WIDTH-1:0] tag,
  input  cdb_t                cdb [NUM_CDB],
  output logic                hit
);

  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb[k].cdb_valid && (cdb[k].arch_reg != 5'd0) && (cdb[k].phys_reg == tag)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue with CDB operand wakeup and a registered
// issue slot feeding the memory functional unit.
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : mispredict clear, synchronous, dominates all else
//   enq_valid/ready   : enqueue handshake (ready = not full)
//   enq_*             : enqueue payload
//   cdb               : NUM_CDB broadcast ports snooped for wakeup
//   rob_head_is_store : ROB head is a store ...
//   rob_head_idx      : ... with this ROB index (stores wait for this)
//   iss_valid/entry   : registered issue slot to the memory FU
//   iss_ready         : memory FU accepts the slot
//   count             : number of occupied queue entries
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module load_store_queue
  import rv32i_types::*;
#(
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic                    enq_is_store,
  input  logic [2:0]              enq_funct3,
  input  logic [31:0]             enq_offset,
  input  logic [ROB_WIDTH-1:0]    enq_rob,
  input  logic [PR_WIDTH-1:0]     enq_prs1,
  input  logic [PR_WIDTH-1:0]     enq_prs2,
  input  logic                    enq_prs1_rdy,
  input  logic                    enq_prs2_rdy,
  input  logic [PR_WIDTH-1:0]     enq_pdest,
  input  logic [4:0]              enq_arch_dest,
  input  cdb_t                    cdb [NUM_CDB],
  input  logic                    rob_head_is_store,
  input  logic [ROB_WIDTH-1:0]    rob_head_idx,
  output logic                    iss_valid,
  output lsq_entry_t              iss_entry,
  input  logic                    iss_ready,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  lsq_entry_t       entries_reg [DEPTH];
  logic [PW-1:0]    head_reg;
  logic [PW-1:0]    tail_reg;
  logic [CW-1:0]    count_reg;
  logic             iss_valid_reg;
  lsq_entry_t       iss_entry_reg;

  logic [DEPTH-1:0] hit1;
  logic [DEPTH-1:0] hit2;
  logic             enq_hit1;
  logic             enq_hit2;
  lsq_entry_t       enq_entry;
  lsq_entry_t       head_entry;
  logic             head_eligible;
  logic             slot_free;
  logic             do_enq;
  logic             do_pop;

  // Per-entry wakeup for both operands.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wake
    lsq_wakeup #(.NUM_CDB(NUM_CDB)) u_wake_addr (
      .tag (entries_reg[gi].prs1),
      .cdb (cdb),
      .hit (hit1[gi])
    );
    lsq_wakeup #(.NUM_CDB(NUM_CDB)) u_wake_data (
      .tag (entries_reg[gi].prs2),
      .cdb (cdb),
      .hit (hit2[gi])
    );
  end

  // Wakeup on the incoming payload so a broadcast coinciding with
  // enqueue is not lost.
  lsq_wakeup #(.NUM_CDB(NUM_CDB)) u_wake_enq_addr (
    .tag (enq_prs1),
    .cdb (cdb),
    .hit (enq_hit1)
  );
  lsq_wakeup #(.NUM_CDB(NUM_CDB)) u_wake_enq_data (
    .tag (enq_prs2),
    .cdb (cdb),
    .hit (enq_hit2)
  );

  always_comb begin
    enq_entry           = '0;
    enq_entry.valid     = 1'b1;
    enq_entry.is_store  = enq_is_store;
    enq_entry.funct3    = enq_funct3;
    enq_entry.offset    = enq_offset;
    enq_entry.rob       = enq_rob;
    enq_entry.prs1      = enq_prs1;
    enq_entry.addr_rdy  = enq_prs1_rdy | enq_hit1;
    enq_entry.prs2      = enq_prs2;
    enq_entry.data_rdy  = enq_prs2_rdy | enq_hit2;
    enq_entry.pdest     = enq_pdest;
    enq_entry.arch_dest = enq_arch_dest;
  end

  assign head_entry = entries_reg[head_reg];

  // Eligibility uses only registered ready bits, so an entry can never
  // leave the queue in the same cycle it arrives.
  always_comb begin
    head_eligible = 1'b0;
    if ((count_reg != '0) && head_entry.valid && head_entry.addr_rdy) begin
      if (!head_entry.is_store) begin
        head_eligible = 1'b1;
      end else begin
        head_eligible = head_entry.data_rdy && rob_head_is_store &&
                        (rob_head_idx == head_entry.rob);
      end
    end
  end

  assign enq_ready = (count_reg != FULL_COUNT);
  assign slot_free = !iss_valid_reg || iss_ready;
  assign do_enq    = enq_valid && enq_ready && !flush;
  assign do_pop    = head_eligible && slot_free && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_reg[i] <= '0;
      end
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      iss_valid_reg <= 1'b0;
      iss_entry_reg <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_reg[i].valid <= 1'b0;
      end
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      iss_valid_reg <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (hit1[i]) entries_reg[i].addr_rdy <= 1'b1;
        if (hit2[i]) entries_reg[i].data_rdy <= 1'b1;
      end
      // Pop and enqueue never target the same slot: that would need an
      // empty queue (no pop) or a full one (no enqueue).
      if (do_pop) begin
        entries_reg[head_reg].valid <= 1'b0;
        head_reg <= head_reg + 1'b1;
      end
      if (do_enq) begin
        entries_reg[tail_reg] <= enq_entry;
        tail_reg <= tail_reg + 1'b1;
      end
      case ({do_enq, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (do_pop) begin
        iss_valid_reg <= 1'b1;
        iss_entry_reg <= head_entry;
      end else if (iss_ready) begin
        iss_valid_reg <= 1'b0;
      end
    end
  end

  assign iss_valid = iss_valid_reg;
  assign iss_entry = iss_entry_reg;
  assign count     = count_reg;

endmodule
